// File: rtl/maxnet_pkg.sv
// Shared types and constants for the Maxnet controller.
// Holds the FSM state encoding, neuron count, FP constants and defaults.
package maxnet_pkg;

    localparam int N = 4;

    localparam logic [31:0] ONE     = 32'h3F80_0000;
    localparam logic [31:0] EPS_NEG = 32'hBE4C_CCCD;

    localparam int MAC_LAT_DEF  = 2;
    localparam int MAX_ITER_DEF = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAC,
        S_DRAIN,
        S_WB,
        S_COMMIT,
        S_CHECK,
        S_DONE
    } state_t;

    function automatic logic [2:0] popcnt4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]}
             + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

endpackage

// File: rtl/maxnet_step_counter.sv
// 2-bit row/column step counter with a terminal-count flag.
// clr has priority over inc; last is high while the count is 3.
module maxnet_step_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       inc,
    output logic [1:0] cnt,
    output logic       last
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 2'd0;
        end else if (clr) begin
            cnt <= 2'd0;
        end else if (inc) begin
            cnt <= cnt + 2'd1;
        end
    end

    assign last = &cnt;

endmodule

// File: rtl/maxnet_controller.sv
// Maxnet winner-take-all sequencer driving a shared FP MAC.
// Strobe outputs are registered from the next-state decode.
module maxnet_controller
    import maxnet_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MAC_LAT  = MAC_LAT_DEF,
    parameter int MAX_ITER = MAX_ITER_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] nz,
    output logic [1:0] w_row,
    output logic [1:0] w_col,
    output logic       mac_clr,
    output logic       mac_en,
    output logic       a_we,
    output logic [1:0] wb_row,
    output logic       commit,
    output logic       busy,
    output logic       done,
    output logic       timeout,
    output logic [7:0] iter
);

    if (XLEN != 32 || MAC_LAT < 1 || MAC_LAT > 7 ||
        MAX_ITER < 1 || MAX_ITER > 255) begin : g_bad_param
        $error("maxnet_controller: illegal parameter");
    end

    localparam logic [2:0] DRAIN_LAST = 3'(MAC_LAT - 1);
    localparam logic [7:0] ITER_LIM   = 8'(MAX_ITER);

    state_t     state;
    state_t     nstate;
    logic [1:0] row;
    logic [1:0] col;
    logic       row_last;
    logic       col_last;
    logic       cnt_clr;
    logic       row_inc;
    logic       col_inc;
    logic [2:0] dcnt;
    logic [7:0] iter_inc;
    logic       conv;
    logic       hit_lim;
    logic       in_row;

    assign iter_inc = iter + 8'd1;
    assign conv     = popcnt4(nz) <= 3'd1;
    assign hit_lim  = iter_inc == ITER_LIM;

    assign cnt_clr = (state == S_IDLE) || (state == S_CHECK);
    assign row_inc = (state == S_WB) && !row_last;
    assign col_inc = (state == S_MAC);

    maxnet_step_counter u_row (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (cnt_clr),
        .inc  (row_inc),
        .cnt  (row),
        .last (row_last)
    );

    maxnet_step_counter u_col (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (cnt_clr),
        .inc  (col_inc),
        .cnt  (col),
        .last (col_last)
    );

    always_comb begin
        nstate = state;
        unique case (state)
            S_IDLE:   if (start) nstate = S_MAC;
            S_MAC:    if (col_last) nstate = S_DRAIN;
            S_DRAIN:  if (dcnt == DRAIN_LAST) nstate = S_WB;
            S_WB:     nstate = row_last ? S_COMMIT : S_MAC;
            S_COMMIT: nstate = S_CHECK;
            S_CHECK:  nstate = (conv || hit_lim) ? S_DONE : S_MAC;
            S_DONE:   nstate = S_IDLE;
            default:  nstate = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            dcnt    <= 3'd0;
            iter    <= 8'd0;
            timeout <= 1'b0;
            mac_en  <= 1'b0;
            mac_clr <= 1'b0;
            a_we    <= 1'b0;
            commit  <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= nstate;
            dcnt    <= (state == S_DRAIN) ? dcnt + 3'd1 : 3'd0;
            mac_en  <= nstate == S_MAC;
            // a fresh row always starts at column 0
            mac_clr <= (nstate == S_MAC) && (state != S_MAC);
            a_we    <= nstate == S_WB;
            commit  <= nstate == S_COMMIT;
            done    <= nstate == S_DONE;
            if (state == S_IDLE && start) begin
                iter    <= 8'd0;
                timeout <= 1'b0;
            end else if (state == S_CHECK) begin
                iter    <= iter_inc;
                timeout <= !conv && hit_lim;
            end
        end
    end

    assign in_row = (state == S_MAC) || (state == S_DRAIN)
                 || (state == S_WB);
    assign busy   = state != S_IDLE;
    assign w_row  = in_row ? row : 2'd0;
    assign w_col  = in_row ? col : 2'd0;
    assign wb_row = (state == S_WB) ? row : 2'd0;

endmodule
